// File: rtl/bram_stream_reader.sv
// bram_stream_reader
//   Read-side controller for a single-port block RAM with a 1-cycle registered
//   read. On a start command it walks a contiguous address range, wrapping at
//   p_RAM_DEPTH-1. It streams the returned words out over valid/ready through a
//   2-entry buffer and flags the final word with o_last.
//
// Ports
//   i_clk, i_rstn        clock, asynchronous active-low reset
//   i_start              command strobe, only honoured in IDLE
//   in_start_addr/in_len first address / word count (0 legal)
//   o_busy, o_done       command in progress / one-cycle completion pulse
//   on_bram_addr         RAM address (registered)
//   o_bram_wren          RAM write enable, always 0
//   in_bram_data         RAM read data, valid the cycle after its address
//   on_data/o_valid/o_last/i_ready  output stream
module bram_stream_reader #(
  parameter int p_RAM_WIDTH = 8,
  parameter int p_RAM_DEPTH = 32,
  localparam int AW = $clog2(p_RAM_DEPTH),
  localparam int LW = AW + 1
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic                   i_start,
  input  logic [AW-1:0]          in_start_addr,
  input  logic [LW-1:0]          in_len,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [AW-1:0]          on_bram_addr,
  output logic                   o_bram_wren,
  input  logic [p_RAM_WIDTH-1:0] in_bram_data,
  output logic [p_RAM_WIDTH-1:0] on_data,
  output logic                   o_valid,
  output logic                   o_last,
  input  logic                   i_ready
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t state, state_nx;

  logic [AW-1:0] addr, addr_nx;
  logic [LW-1:0] len_q, issue_cnt;
  logic          infl, infl_last;   // word on the RAM data bus, to be captured
  logic [1:0][p_RAM_WIDTH-1:0] fifo_data;
  logic [1:0]    fifo_last;
  logic          wr_ptr, rd_ptr;
  logic [1:0]    fifo_cnt;
  logic [1:0]    occ;
  logic          hs, issue, issue_last, head_last, push;

  assign hs         = o_valid & i_ready;
  assign push       = infl;
  assign occ        = fifo_cnt + {1'b0, infl};
  assign issue_last = (issue_cnt == len_q - LW'(1));
  assign head_last  = fifo_last[rd_ptr];

  // The address currently on the port is counted as a read when issued; at most
  // two words may be outstanding (buffered + on the bus), but a pop in the same
  // cycle frees a slot so the stream sustains one word per clock.
  assign issue = (state == S_READ) && (issue_cnt < len_q) &&
                 ((occ < 2'd2) || hs);

  assign addr_nx = (addr == AW'(p_RAM_DEPTH - 1)) ? '0 : addr + AW'(1);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= S_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (i_start) state_nx = (in_len == '0) ? S_DONE : S_READ;
      S_READ: begin
        if (hs && head_last)          state_nx = S_DONE;
        else if (issue && issue_last) state_nx = S_DRAIN;
      end
      S_DRAIN: if (hs && head_last) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Command registers and address walker
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      addr      <= '0;
      len_q     <= '0;
      issue_cnt <= '0;
      infl      <= 1'b0;
      infl_last <= 1'b0;
    end else begin
      if (state == S_IDLE && i_start) begin
        addr      <= in_start_addr;
        len_q     <= in_len;
        issue_cnt <= '0;
      end else if (issue) begin
        addr      <= addr_nx;
        issue_cnt <= issue_cnt + LW'(1);
      end
      infl      <= issue;
      infl_last <= issue & issue_last;
    end
  end

  // 2-entry output buffer; the last flag travels with its word
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      fifo_data <= '0;
      fifo_last <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      fifo_cnt  <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= in_bram_data;
        fifo_last[wr_ptr] <= infl_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (hs) rd_ptr <= ~rd_ptr;
      case ({push, hs})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign o_valid      = (fifo_cnt != 2'd0);
  assign on_data      = fifo_data[rd_ptr];
  assign o_last       = o_valid & head_last;
  assign o_busy       = (state == S_READ) || (state == S_DRAIN);
  assign o_done       = (state == S_DONE);
  assign on_bram_addr = addr;
  assign o_bram_wren  = 1'b0;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Self-checking bench for bram_stream_reader: table of directed commands,
// randomized commands against a queue-based stream model, plus hand sequences
// for reset mid-command and wrap on a non power-of-two depth.
module tb_bram_stream_reader;

  logic       i_clk, i_rstn;
  logic       i_start, i_ready;
  logic [4:0] in_start_addr, on_bram_addr;
  logic [5:0] in_len;
  logic       o_busy, o_done, o_bram_wren, o_valid, o_last;
  logic [7:0] in_bram_data, on_data;

  logic       start2, ready2, busy2, done2, wren2, valid2, last2;
  logic [4:0] saddr2, baddr2;
  logic [5:0] len2;
  logic [7:0] bdata2, data2;

  int checks = 0;
  int errors = 0;

  bram_stream_reader #(.p_RAM_WIDTH(8), .p_RAM_DEPTH(32)) u_dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start),
    .in_start_addr(in_start_addr), .in_len(in_len),
    .o_busy(o_busy), .o_done(o_done), .on_bram_addr(on_bram_addr),
    .o_bram_wren(o_bram_wren), .in_bram_data(in_bram_data),
    .on_data(on_data), .o_valid(o_valid), .o_last(o_last), .i_ready(i_ready));

  bram_stream_reader #(.p_RAM_WIDTH(8), .p_RAM_DEPTH(20)) u_dut20 (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_start(start2),
    .in_start_addr(saddr2), .in_len(len2),
    .o_busy(busy2), .o_done(done2), .on_bram_addr(baddr2),
    .o_bram_wren(wren2), .in_bram_data(bdata2),
    .on_data(data2), .o_valid(valid2), .o_last(last2), .i_ready(ready2));

  // RAM contents mem[a] = a + 8'h10, registered read
  always @(posedge i_clk) begin
    in_bram_data <= {3'b000, on_bram_addr} + 8'h10;
    bdata2       <= {3'b000, baddr2} + 8'h10;
  end

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  int pat[6] = '{1, 0, 0, 1, 0, 1};

  // Issue one command to the depth-32 instance and check the whole stream.
  task automatic run_cmd(input int sa, input int ln, input int mode, input int poke,
                         output int first_d, output int last_d, output int nw);
    int q[$];
    int cyc, first_v, last_hs, done_cyc, acc, off, e;
    bit done_seen, stall;
    logic [7:0] pd;
    logic pl;
    for (int i = 0; i < ln; i++) q.push_back(((sa + i) % 32) + 16);
    first_d = -1; last_d = -1; nw = 0; acc = 0;
    first_v = -1; last_hs = -1; done_cyc = -1; done_seen = 0; stall = 0;
    pd = '0; pl = 1'b0;
    in_start_addr = 5'(sa); in_len = 6'(ln); i_start = 1'b1; i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    cyc = 1;
    for (int k = 0; k < 400 && !done_seen; k++) begin
      if (cyc == poke) begin
        i_start = 1'b1; in_start_addr = 5'd1; in_len = 6'd2;
      end else begin
        i_start = 1'b0;
      end
      case (mode)
        0:       i_ready = 1'b1;
        1:       i_ready = pat[k % 6][0];
        default: i_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge i_clk);
      if (stall) chk("stall_hold", {o_valid, o_last, on_data}, {1'b1, pl, pd});
      if (mode == 0 && cyc <= ln) chk("addr_seq", on_bram_addr, (sa + cyc - 1) % 32);
      if (ln > 0 && ln <= 32 && !o_done) begin
        off = (int'(on_bram_addr) - sa + 32) % 32;
        chk("addr_ahead", (off <= acc + 2), 1);
      end
      if (ln == 0) chk("no_valid_zero_len", o_valid, 0);
      chk("busy", o_busy, (ln != 0) && !o_done);
      chk("no_overflow", (u_dut.fifo_cnt <= 2'd2), 1);
      if (o_valid && i_ready) begin
        if (q.size() == 0) begin
          chk("overrun", nw + 1, ln);
        end else begin
          e = q.pop_front();
          chk("data", on_data, e);
          chk("last", o_last, q.size() == 0);
        end
        if (first_d < 0) first_d = on_data;
        last_d = on_data; nw++; acc++; last_hs = cyc;
      end
      if (o_valid && first_v < 0) first_v = cyc;
      if (o_done) begin done_seen = 1; done_cyc = cyc; end
      stall = o_valid && !i_ready;
      pd = on_data; pl = o_last;
      @(posedge i_clk); #1;
      cyc++;
    end
    i_start = 1'b0;
    chk("done_seen", done_seen, 1);
    if (ln == 0) chk("done_cycle_zero", done_cyc, 1);
    else         chk("done_after_last", done_cyc, last_hs + 1);
    if (ln > 0 && mode == 0) begin
      chk("first_valid_cycle", first_v, 3);
      chk("no_bubbles", last_hs - first_v, ln - 1);
    end
    @(negedge i_clk);
    chk("done_single_pulse", o_done, 0);
    chk("busy_after_done", o_busy, 0);
    @(posedge i_clk); #1;
  endtask

  typedef struct {
    int sa; int ln; int mode; int poke;
    int exp_first; int exp_last; int exp_n;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int fd, ld, n, acc, sa, ln, e;
    bit dn;
    int q2[$];

    vecs[0] = '{3, 4, 0, -1, 'h13, 'h16, 4};    // basic read
    vecs[1] = '{3, 4, 1, -1, 'h13, 'h16, 4};    // backpressure
    vecs[2] = '{30, 4, 0, -1, 'h2E, 'h11, 4};   // wrap 30,31,0,1
    vecs[3] = '{0, 0, 0, -1, -1, -1, 0};        // zero length
    vecs[4] = '{5, 8, 0, 3, 'h15, 'h1C, 8};     // start pulsed mid-command
    vecs[5] = '{31, 1, 1, -1, 'h2F, 'h2F, 1};   // single word at top address
    vecs[6] = '{0, 40, 2, -1, 'h10, 'h17, 40};  // longer than depth

    i_rstn = 1'b0; i_start = 1'b0; i_ready = 1'b0;
    in_start_addr = '0; in_len = '0;
    start2 = 1'b0; ready2 = 1'b0; saddr2 = '0; len2 = '0;
    #3;
    chk("rst_valid", o_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_last", o_last, 0);
    chk("rst_addr", on_bram_addr, 0);
    chk("rst_data", on_data, 0);
    chk("wren_zero", {o_bram_wren, wren2}, 0);
    #9 i_rstn = 1'b1;
    @(posedge i_clk); #1;

    for (int v = 0; v < 7; v++) begin
      run_cmd(vecs[v].sa, vecs[v].ln, vecs[v].mode, vecs[v].poke, fd, ld, n);
      chk($sformatf("vec%0d_count", v), n, vecs[v].exp_n);
      if (vecs[v].exp_n > 0) begin
        chk($sformatf("vec%0d_first", v), fd, vecs[v].exp_first);
        chk($sformatf("vec%0d_lastword", v), ld, vecs[v].exp_last);
      end
    end

    for (int r = 0; r < 25; r++) begin
      sa = $urandom_range(0, 31);
      ln = $urandom_range(0, 40);
      run_cmd(sa, ln, 2, -1, fd, ld, n);
      chk("rand_count", n, ln);
    end

    // Reset in the middle of a len=8 command, after two words
    in_start_addr = 5'd0; in_len = 6'd8; i_start = 1'b1; i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    acc = 0;
    for (int k = 0; k < 20 && acc < 2; k++) begin
      @(negedge i_clk);
      if (o_valid && i_ready) acc++;
    end
    chk("reset_pre_words", acc, 2);
    #2 i_rstn = 1'b0;
    #1;
    chk("rstmid_valid", o_valid, 0);
    chk("rstmid_busy", o_busy, 0);
    chk("rstmid_last", o_last, 0);
    chk("rstmid_addr", on_bram_addr, 0);
    chk("rstmid_data", on_data, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      chk("rstmid_no_done", o_done, 0);
    end
    i_rstn = 1'b1;
    @(posedge i_clk); #1;
    @(negedge i_clk);
    chk("post_reset_idle", {o_busy, o_done, o_valid}, 0);
    @(posedge i_clk); #1;
    run_cmd(0, 2, 0, -1, fd, ld, n);
    chk("post_reset_count", n, 2);
    chk("post_reset_first", fd, 'h10);
    chk("post_reset_lastword", ld, 'h11);

    // Wrap on depth 20: addresses 18,19,0
    for (int i = 0; i < 3; i++) q2.push_back(((18 + i) % 20) + 16);
    saddr2 = 5'd18; len2 = 6'd3; start2 = 1'b1; ready2 = 1'b1;
    @(posedge i_clk); #1;
    start2 = 1'b0;
    dn = 0; n = 0;
    for (int c = 1; c < 20 && !dn; c++) begin
      @(negedge i_clk);
      if (c <= 3) chk("wrap20_addr", baddr2, (18 + c - 1) % 20);
      chk("wrap20_addr_range", (baddr2 < 5'd20), 1);
      if (valid2 && ready2) begin
        if (q2.size() == 0) begin
          chk("wrap20_overrun", n + 1, 3);
        end else begin
          e = q2.pop_front();
          chk("wrap20_data", data2, e);
          chk("wrap20_last", last2, q2.size() == 0);
        end
        n++;
      end
      if (done2) dn = 1;
      @(posedge i_clk); #1;
    end
    chk("wrap20_done", dn, 1);
    chk("wrap20_count", n, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
